reg_file_16x32_wr: RTL
======================

Name: reg_file_16x32_wr

Overview:
Write side of the 16x32 general-purpose register file. Its Q0-Q15 outputs feed the two 16x1 source-operand muxes.
- ALU write port: single-cycle, highest priority.
- Load write port: valid/ready handshake, buffered in a 2-entry FIFO.
- pend_mask exposes in-flight loads for hazard detection.

Parameters:
DATA_W, 32, register width
NREG, 16, register count (fixed; sel is 4 bits)
LDQ_DEPTH, 2, load FIFO depth (only 2 supported)
ZERO_R0, 0, when 1, writes to R0 are dropped and Q0 always reads 0

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
alu_we  in  1  ALU write enable this cycle
alu_sel  in  4  ALU destination register index
alu_data  in  32  ALU write data
ld_valid  in  1  load result offered
ld_ready  out  1  load result can be accepted
ld_sel  in  4  load destination register index
ld_data  in  32  load write data
Q0..Q15  out  32 each  current register contents, to the source muxes
pend_mask  out  16  bit i set while a live (non-stale) load to Ri sits in the FIFO

Behaviour:
- Reset (async, rst_n=0): all R0-R15 = 0, FIFO empty, all stale flags cleared, pend_mask = 0, ld_ready = 0 while rst_n=0. ld_ready = 1 from the first cycle after release.
- Q outputs come directly from the registers. There is no write-to-read bypass. A write at edge t is visible on Q after edge t.
- ALU write: if alu_we=1, R[alu_sel] <= alu_data at the next edge. Latency is 1 edge. It never stalls.
- Load accept: a handshake occurs when ld_valid && ld_ready at an edge. {ld_sel, ld_data} is pushed to the FIFO tail with stale=0.
- ld_ready = (count < 2). It depends only on registered count, with no same-cycle drain pass-through. When count=2, ld_ready=0 even if a drain happens that cycle.
- Drain: at an edge with alu_we=0 and count>0, the head is popped.
  - If the head is not stale, R[head.sel] <= head.data.
  - If the head is stale, it is popped and discarded with no write.
  - If alu_we=1, nothing drains (ALU owns the single register write port).
- Load latency: an entry accepted at edge t drains at the earliest at edge t+1. It is visible on Q after t+1 if no ALU write occurs in cycle t+1.
- Simultaneous push and pop: count is unchanged, FIFO order is preserved, and the new entry goes behind the remaining entry.
- Stale (ALU overtakes an older load): when alu_we=1 and alu_sel equals the sel of a FIFO entry already present before this edge, that entry's stale flag is set.
  - A load accepted in the same cycle as an ALU write to the same register is treated as younger and is not marked stale.
- pend_mask: bit i = OR over valid, non-stale FIFO entries with sel=i. It is combinational from FIFO state, so it updates the cycle after push, pop, or stale marking.
- ZERO_R0=1: writes to R0 (ALU or drain) are suppressed and Q0 = 0. A load to R0 is still accepted and drained, but never sets pend_mask[0].
- Mid-operation reset: asserting rst_n discards the FIFO contents and clears all registers immediately (asynchronous).
- FIFO pointers: 1-bit rd/wr pointers that wrap modulo 2, plus a 2-bit count (0..2). Overflow is impossible by construction of ld_ready.

Decomposition:
- Shared package: DATA_W, NREG, the REG_SEL_W=4 constant, and the load-entry struct {sel[3:0], data[31:0], stale}.
- One sub-module: ld_wb_fifo, the 2-entry FIFO with a per-entry stale-marking input (match sel) and a per-entry pending-mask output.
- The register array, write-select decode and ALU/drain arbitration stay in the top module.

Test Plan:
- Reset then ALU write: alu_we=1, sel=5, data=0xDEADBEEF for one cycle -> Q5=0xDEADBEEF after the edge; all other Q remain 0; pend_mask=0.
- Load alone: ld_valid=1, sel=3, data=0x12345678 accepted at edge t, alu_we=0 -> pend_mask=0x0008 after t; Q3=0x12345678 and pend_mask=0 after t+1.
- Backpressure: ld_valid held high with alu_we=1 continuously, loads to R1 and R2 -> two accepts, then ld_ready=0. Drop alu_we -> R1 is written, then R2, in order; ld_ready returns to 1 the cycle after the first pop.
- Stale: load to R7 (0x1111) sits in the FIFO while alu_we=1 keeps blocking it; then ALU writes R7=0x2222 -> pend_mask[7] clears; on drain R7 stays 0x2222.
- Same-cycle collision: ld accept sel=9 data=0xAAAA and alu_we sel=9 data=0xBBBB in the same cycle -> R9=0xBBBB, then R9=0xAAAA one edge later; pend_mask[9] set in between.
- Async reset mid-drain: FIFO holds 2 entries, pull rst_n low between edges -> Q0-Q15=0, pend_mask=0 and ld_ready=0 immediately; after release, no stale write ever occurs.

Source files
------------

// File: rtl/reg_file_16x32_wr_pkg.sv
// Shared types and constants for the 16x32 register-file write side.
// The load-entry struct is the unit stored in the load write-back FIFO.
package reg_file_16x32_wr_pkg;

    localparam int DATA_W    = 32;
    localparam int NREG      = 16;
    localparam int REG_SEL_W = 4;

    typedef struct packed {
        logic [REG_SEL_W-1:0] sel;
        logic [DATA_W-1:0]    data;
        logic                 stale;
    } ld_entry_t;

    function automatic logic [NREG-1:0] sel_onehot(input logic [REG_SEL_W-1:0] sel);
        logic [NREG-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ld_wb_fifo.sv
// Two-entry load write-back FIFO with per-entry stale marking and a
// pending-register mask covering live (non-stale) entries.
module ld_wb_fifo
    import reg_file_16x32_wr_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_req,
    input  logic [REG_SEL_W-1:0] push_sel,
    input  logic [DATA_W-1:0]    push_data,
    output logic                 can_push,
    input  logic                 pop_req,
    output logic                 pop_done,
    output ld_entry_t            head,
    input  logic                 mark_en,
    input  logic [REG_SEL_W-1:0] mark_sel,
    output logic [NREG-1:0]      pend_mask
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    ld_entry_t  mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       rdy_q;
    logic [1:0] slot_valid;
    logic       push_fire;

    // Ready is held low through reset and only rises on the first edge after release.
    assign can_push  = rdy_q && (count < FULL);
    assign push_fire = push_req && can_push;
    assign pop_done  = pop_req && (count != 2'd0);
    assign head      = mem[rd_ptr];

    always_comb begin
        slot_valid = '0;
        if (count == 2'd2) begin
            slot_valid = '1;
        end else if (count == 2'd1) begin
            slot_valid[rd_ptr] = 1'b1;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (slot_valid[i] && !mem[i].stale &&
                !((ZERO_R0 != 0) && (mem[i].sel == '0))) begin
                pend_mask[mem[i].sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            // Only entries present before this edge can be overtaken; the push
            // slot is always free, so a same-cycle load is never marked.
            for (int i = 0; i < 2; i++) begin
                if (mark_en && slot_valid[i] && (mem[i].sel == mark_sel)) begin
                    mem[i].stale <= 1'b1;
                end
            end
            if (push_fire) begin
                mem[wr_ptr] <= '{sel: push_sel, data: push_data, stale: 1'b0};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_done) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_fire, pop_done})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_16x32_wr.sv
// Write side of the 16x32 register file: single write port shared by the
// ALU (priority) and the load write-back FIFO drain.
module reg_file_16x32_wr #(
    parameter int DATA_W    = 32,
    parameter int NREG      = 16,
    parameter int LDQ_DEPTH = 2,
    parameter int ZERO_R0   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_we,
    input  logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [3:0]        ld_sel,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] Q0,
    output logic [DATA_W-1:0] Q1,
    output logic [DATA_W-1:0] Q2,
    output logic [DATA_W-1:0] Q3,
    output logic [DATA_W-1:0] Q4,
    output logic [DATA_W-1:0] Q5,
    output logic [DATA_W-1:0] Q6,
    output logic [DATA_W-1:0] Q7,
    output logic [DATA_W-1:0] Q8,
    output logic [DATA_W-1:0] Q9,
    output logic [DATA_W-1:0] Q10,
    output logic [DATA_W-1:0] Q11,
    output logic [DATA_W-1:0] Q12,
    output logic [DATA_W-1:0] Q13,
    output logic [DATA_W-1:0] Q14,
    output logic [DATA_W-1:0] Q15,
    output logic [15:0]       pend_mask
);
    import reg_file_16x32_wr_pkg::*;

    logic [DATA_W-1:0]    regs [NREG];
    ld_entry_t            head;
    logic                 pop_done;
    logic                 wr_en;
    logic [REG_SEL_W-1:0] wr_sel;
    logic [DATA_W-1:0]    wr_data;
    logic [NREG-1:0]      wr_onehot;

    ld_wb_fifo #(
        .DEPTH   (LDQ_DEPTH),
        .ZERO_R0 (ZERO_R0)
    ) u_ldq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_req  (ld_valid),
        .push_sel  (ld_sel),
        .push_data (ld_data),
        .can_push  (ld_ready),
        .pop_req   (!alu_we),
        .pop_done  (pop_done),
        .head      (head),
        .mark_en   (alu_we),
        .mark_sel  (alu_sel),
        .pend_mask (pend_mask)
    );

    // ALU owns the port whenever it writes; a stale head is popped with no write.
    always_comb begin
        wr_en   = 1'b0;
        wr_sel  = '0;
        wr_data = '0;
        if (alu_we) begin
            wr_en   = 1'b1;
            wr_sel  = alu_sel;
            wr_data = alu_data;
        end else if (pop_done && !head.stale) begin
            wr_en   = 1'b1;
            wr_sel  = head.sel;
            wr_data = head.data;
        end
        if ((ZERO_R0 != 0) && (wr_sel == '0)) begin
            wr_en = 1'b0;
        end
    end

    assign wr_onehot = wr_en ? sel_onehot(wr_sel) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_onehot[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    assign Q0  = (ZERO_R0 != 0) ? '0 : regs[0];
    assign Q1  = regs[1];
    assign Q2  = regs[2];
    assign Q3  = regs[3];
    assign Q4  = regs[4];
    assign Q5  = regs[5];
    assign Q6  = regs[6];
    assign Q7  = regs[7];
    assign Q8  = regs[8];
    assign Q9  = regs[9];
    assign Q10 = regs[10];
    assign Q11 = regs[11];
    assign Q12 = regs[12];
    assign Q13 = regs[13];
    assign Q14 = regs[14];
    assign Q15 = regs[15];

endmodule
